a4_tree_pipe: RTL

Parametrised, pipelined successor to the 4-input AND cell: reduces a WIDTH-bit input vector with a tree of 4-input AND levels, registering every level. It adds a valid/ready handshake with backpressure, a per-transaction NAND mode and a per-transaction sticky-accumulate mode. It is a standard-cell-library macro, used wherever a wide AND/NAND reduction must meet timing at speed.

---
 rtl/a4_tree_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/a4_tree_pipe.sv
// a4_tree_pipe: pipelined wide AND/NAND reduction built from 4-input AND levels,
// with a valid/ready handshake, per-transaction invert and a sticky accumulator.
module a4_tree_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic [WIDTH-1:0] i,
  input  logic             iv,
  output logic             irdy,
  input  logic             inv,
  input  logic             acc,
  input  logic             clr,
  output logic             q,
  output logic             qv,
  input  logic             ordy
);

  // Number of live bits after k levels of 4:1 reduction.
  function automatic int unsigned lvl_w(input int unsigned k);
    int unsigned w;
    w = WIDTH;
    for (int unsigned n = 0; n < k; n++) w = (w + 3) / 4;
    return w;
  endfunction

  // Smallest LAT >= 1 with 4^LAT >= WIDTH.
  function automatic int unsigned calc_lat();
    int unsigned l;
    int unsigned w;
    l = 1;
    w = (WIDTH + 3) / 4;
    for (int n = 0; n < 8; n++) begin
      if (w > 1) begin
        w = (w + 3) / 4;
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int unsigned LAT = calc_lat();

  logic adv;
  logic r;
  logic v_in;
  logic inv_in;
  logic acc_in;
  logic a;
  logic a_eff;
  logic a_d;
  logic q_d;
  logic qv_d;

  // The whole pipeline moves together whenever the output slot is free or drains.
  assign adv  = ~qv | ordy;
  assign irdy = adv;

  genvar k, j;

  // Combinational reduction feeding each level; short top groups padded with 1s.
  for (k = 1; k <= LAT; k++) begin : g_red
    localparam int unsigned LWP = lvl_w(k - 1);
    localparam int unsigned LW  = lvl_w(k);
    localparam int unsigned PW  = 4 * LW;

    logic [LWP-1:0] src;
    logic [PW-1:0]  pad;
    logic [LW-1:0]  red;

    if (k == 1) begin : g_src_in
      assign src = i;
    end else begin : g_src_stg
      assign src = g_stg[k-1].d_q;
    end

    assign pad = PW'({{PW{1'b1}}, src});

    for (j = 0; j < LW; j++) begin : g_and
      assign red[j] = &pad[4*j +: 4];
    end
  end

  // Intermediate level registers: partial AND plus the transaction's control bits.
  for (k = 1; k < LAT; k++) begin : g_stg
    localparam int unsigned LW = lvl_w(k);

    logic [LW-1:0] d_q;
    logic          v_q;
    logic          inv_q;
    logic          acc_q;
    logic          v_d;
    logic          inv_d;
    logic          acc_d;

    if (k == 1) begin : g_ctl_in
      assign v_d   = iv;
      assign inv_d = inv;
      assign acc_d = acc;
    end else begin : g_ctl_stg
      assign v_d   = g_stg[k-1].v_q;
      assign inv_d = g_stg[k-1].inv_q;
      assign acc_d = g_stg[k-1].acc_q;
    end

    // Level register: load from the previous level on advance, hold otherwise.
    always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
        d_q   <= '0;
        v_q   <= 1'b0;
        inv_q <= 1'b0;
        acc_q <= 1'b0;
      end else if (adv) begin
        d_q   <= g_red[k].red;
        v_q   <= v_d;
        inv_q <= inv_d;
        acc_q <= acc_d;
      end
    end
  end

  // Final-level inputs come straight from the ports when the tree is one level deep.
  if (LAT == 1) begin : g_out_in
    assign v_in   = iv;
    assign inv_in = inv;
    assign acc_in = acc;
  end else begin : g_out_stg
    assign v_in   = g_stg[LAT-1].v_q;
    assign inv_in = g_stg[LAT-1].inv_q;
    assign acc_in = g_stg[LAT-1].acc_q;
  end

  assign r = g_red[LAT].red[0];

  // Next output/accumulator state; clr restarts accumulation from 1 even when stalled.
  always_comb begin
    q_d   = q;
    qv_d  = qv;
    a_d   = a;
    a_eff = clr ? 1'b1 : a;
    if (clr) a_d = 1'b1;
    if (adv) begin
      qv_d = v_in;
      if (v_in) begin
        if (acc_in) begin
          a_d = a_eff & r;
          q_d = (a_eff & r) ^ inv_in;
        end else begin
          q_d = r ^ inv_in;
        end
      end
    end
  end

  // Output register and accumulator.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      q  <= 1'b0;
      qv <= 1'b0;
      a  <= 1'b1;
    end else begin
      q  <= q_d;
      qv <= qv_d;
      a  <= a_d;
    end
  end

endmodule
